// File: rtl/dcache_flush_engine.sv
// ----------------------------------------------------------------------------
// dcache_flush_engine
//
// Purpose:
//   Memory-side initiator that walks every set/way of the 2-way data cache
//   SRAM and writes each line that needs it back to data memory over the
//   256-bit line interface. Scan order is way outer, set inner. After each
//   completed write-back a one-cycle strobe tells the SRAM to clear the dirty
//   bit of the line that was just written.
//
// Build option:
//   FLUSH_ALL_VALID_EN - when defined, every valid line is written back
//                        regardless of its dirty bit. When undefined (the
//                        default), only valid AND dirty lines are written.
//
// Ports:
//   clk_i             clock, all state on rising edge
//   rst_i             asynchronous active-high reset
//   flush_req_i       start a flush; only looked at while idle
//   flush_busy_o      high while a flush is in progress (CPU stall)
//   flush_done_o      one-cycle completion pulse
//   wb_count_o        lines written back by the last flush
//   sram_idx_o        set index driven to the SRAM read port
//   sram_way_o        way driven to the SRAM read port
//   sram_tag_i        tag entry {valid, dirty, tag[22:0]} at idx/way
//   sram_data_i       line data at idx/way
//   sram_clr_dirty_o  one-cycle strobe: clear dirty bit at idx/way
//   mem_enable_o      memory request valid
//   mem_write_o       request is a write (always with enable)
//   mem_addr_o        byte address {tag, idx, 5'b0}
//   mem_data_o        line being written
//   mem_ack_i         single-cycle memory completion pulse
//
// State table:
//   IDLE  | waiting for flush_req_i
//   READ  | inspect tag at idx/way, launch write-back if needed
//   WRITE | request held on the bus until mem_ack_i
//   CLEAR | dirty-clear strobe for the line just written
//   NEXT  | advance idx/way or finish
//   DONE  | completion pulse, busy drops on exit
// ----------------------------------------------------------------------------
module dcache_flush_engine #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int TAG_W    = 25,
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_req_i,
    output logic                                      flush_busy_o,
    output logic                                      flush_done_o,
    output logic [$clog2(NUM_SETS*NUM_WAYS+1)-1:0]    wb_count_o,
    output logic [$clog2(NUM_SETS)-1:0]               sram_idx_o,
    output logic [((NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1)-1:0] sram_way_o,
    input  logic [TAG_W-1:0]                          sram_tag_i,
    input  logic [LINE_W-1:0]                         sram_data_i,
    output logic                                      sram_clr_dirty_o,
    output logic                                      mem_enable_o,
    output logic                                      mem_write_o,
    output logic [ADDR_W-1:0]                         mem_addr_o,
    output logic [LINE_W-1:0]                         mem_data_o,
    input  logic                                      mem_ack_i
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int CNT_W = $clog2(NUM_SETS * NUM_WAYS + 1);
    localparam int OFF_W = ADDR_W - (TAG_W - 2) - IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

    // Tag entry layout: MSB valid, next bit dirty, the rest address tag.
    localparam int VALID_BIT = TAG_W - 1;
    localparam int DIRTY_BIT = TAG_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CLEAR = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clr_q, clr_d;
    logic                en_q, en_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                need_wb;

`ifdef FLUSH_ALL_VALID_EN
    assign need_wb = sram_tag_i[VALID_BIT];
`else
    // An invalid line is never written, even if its dirty bit is stale.
    assign need_wb = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            way_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        way_d   = way_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clr_d   = 1'b0;
        en_d    = en_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d = ST_READ;
                    idx_d   = '0;
                    way_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            ST_READ: begin
                if (need_wb) begin
                    addr_d  = {sram_tag_i[DIRTY_BIT-1:0], idx_q, {OFF_W{1'b0}}};
                    data_d  = sram_data_i;
                    en_d    = 1'b1;
                    wr_d    = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_NEXT;
                end
            end

            ST_WRITE: begin
                // Latency is unbounded; the request simply waits for ack.
                if (mem_ack_i) begin
                    en_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    clr_d   = 1'b1;
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                state_d = ST_NEXT;
            end

            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    if (way_q == LAST_WAY) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = '0;
                        way_d   = way_q + 1'b1;
                        state_d = ST_READ;
                    end
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_READ;
                end
            end

            ST_DONE: begin
                // A request seen here is dropped; a held request is picked
                // up again once back in IDLE.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    assign flush_busy_o     = busy_q;
    assign flush_done_o     = done_q;
    assign wb_count_o       = cnt_q;
    assign sram_idx_o       = idx_q;
    assign sram_way_o       = way_q;
    assign sram_clr_dirty_o = clr_q;
    assign mem_enable_o     = en_q;
    assign mem_write_o      = wr_q;
    assign mem_addr_o       = addr_q;
    assign mem_data_o       = data_q;

endmodule

// File: tb/tb_dcache_flush_engine.sv
// ----------------------------------------------------------------------------
// tb_dcache_flush_engine
//
// Bench for dcache_flush_engine. The SRAM is an array of tag/data entries
// driven combinationally from the engine's idx/way. Before every flush the
// bench computes, straight from the tag contents, the ordered list of lines
// that must be written, and the expected flush length (65 base cycles plus,
// for each write-back, the cycles spent waiting for ack plus one clear cycle).
// The memory responder acks each write after a chosen delay.
// ----------------------------------------------------------------------------
module tb_dcache_flush_engine;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_req_i;
    logic         flush_busy_o;
    logic         flush_done_o;
    logic [5:0]   wb_count_o;
    logic [3:0]   sram_idx_o;
    logic [0:0]   sram_way_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_clr_dirty_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;

    logic [24:0]  tag_mem  [2][16];
    logic [255:0] data_mem [2][16];

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0]  addr;
        logic [255:0] data;
        int           idx;
        int           way;
    } wb_t;

    always #5 clk_i = ~clk_i;

    assign sram_tag_i  = tag_mem[sram_way_o][sram_idx_o];
    assign sram_data_i = data_mem[sram_way_o][sram_idx_o];

    dcache_flush_engine dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_req_i      (flush_req_i),
        .flush_busy_o     (flush_busy_o),
        .flush_done_o     (flush_done_o),
        .wb_count_o       (wb_count_o),
        .sram_idx_o       (sram_idx_o),
        .sram_way_o       (sram_way_o),
        .sram_tag_i       (sram_tag_i),
        .sram_data_i      (sram_data_i),
        .sram_clr_dirty_o (sram_clr_dirty_o),
        .mem_enable_o     (mem_enable_o),
        .mem_write_o      (mem_write_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .mem_ack_i        (mem_ack_i)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit need_wb(input logic [24:0] t);
`ifdef FLUSH_ALL_VALID_EN
        return t[24];
`else
        return t[24] & t[23];
`endif
    endfunction

    task automatic clear_mem();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 16; i++) begin
                tag_mem[w][i]  = '0;
                data_mem[w][i] = '0;
            end
    endtask

    task automatic random_mem();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 16; i++) begin
                tag_mem[w][i] = 25'($urandom);
                for (int k = 0; k < 8; k++)
                    data_mem[w][i][k*32 +: 32] = $urandom;
            end
    endtask

    // One full flush. fixed_k > 0 forces that many WRITE cycles per line,
    // otherwise 1..6 at random. stray injects requests while busy, acks
    // outside WRITE, and a request on the done cycle.
    task automatic run_flush(input string name, input int fixed_k, input bit stray);
        wb_t exp_q[$];
        wb_t cur;
        wb_t ent;
        int  n_exp;
        int  busy_cnt = 0;
        int  extra    = 0;
        int  wait_ctr = 0;
        int  clr_cnt  = 0;
        int  k;
        bit  in_wait  = 0;
        bit  finished = 0;

        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 16; i++)
                if (need_wb(tag_mem[w][i])) begin
                    ent.addr = {tag_mem[w][i][22:0], 4'(i), 5'b0};
                    ent.data = data_mem[w][i];
                    ent.idx  = i;
                    ent.way  = w;
                    exp_q.push_back(ent);
                end
        n_exp    = exp_q.size();
        cur.addr = 'x;
        cur.data = 'x;
        cur.idx  = -1;
        cur.way  = -1;

        @(negedge clk_i);
        flush_req_i = 1'b1;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge clk_i);
            flush_req_i = 1'b0;
            mem_ack_i   = 1'b0;
            if (flush_busy_o) busy_cnt++;
            if (sram_clr_dirty_o) begin
                clr_cnt++;
                chk({name, ".clr_idx"}, 256'(sram_idx_o), 256'(cur.idx));
                chk({name, ".clr_way"}, 256'(sram_way_o), 256'(cur.way));
                tag_mem[sram_way_o][sram_idx_o][23] = 1'b0;
            end
            if (mem_enable_o) begin
                if (!in_wait) begin
                    in_wait = 1;
                    if (exp_q.size() > 0) cur = exp_q.pop_front();
                    else begin
                        cur.addr = 'x;
                        cur.data = 'x;
                    end
                    chk({name, ".wr_addr"}, 256'(mem_addr_o), 256'(cur.addr));
                    chk({name, ".wr_data"}, mem_data_o, cur.data);
                    chk({name, ".wr_flag"}, 256'(mem_write_o), 256'(1'b1));
                    k = (fixed_k > 0) ? fixed_k : int'($urandom_range(1, 6));
                    wait_ctr = k;
                    extra += k + 1;
                end else begin
                    chk({name, ".hold_addr"}, 256'(mem_addr_o), 256'(cur.addr));
                    chk({name, ".hold_data"}, mem_data_o, cur.data);
                end
                wait_ctr--;
                if (wait_ctr == 0) mem_ack_i = 1'b1;
            end else begin
                in_wait = 0;
                if (stray) begin
                    mem_ack_i   = ($urandom_range(0, 3) == 0);
                    flush_req_i = ($urandom_range(0, 3) == 0);
                end
            end
            if (flush_done_o) begin
                finished = 1;
                chk({name, ".done_time"}, 256'(busy_cnt), 256'(65 + extra));
                chk({name, ".wb_count"}, 256'(wb_count_o), 256'(n_exp));
                if (stray) flush_req_i = 1'b1;
            end
        end
        chk({name, ".finished"}, 256'(finished), 256'(1'b1));
        chk({name, ".missing_writes"}, 256'(exp_q.size()), 256'(0));
        chk({name, ".clr_count"}, 256'(clr_cnt), 256'(n_exp));

        @(negedge clk_i);
        flush_req_i = 1'b0;
        mem_ack_i   = 1'b0;
        chk({name, ".done_pulse"}, 256'(flush_done_o), 256'(1'b0));
        chk({name, ".busy_after"}, 256'(flush_busy_o), 256'(1'b0));
        @(negedge clk_i);
        chk({name, ".no_retrigger"}, 256'(flush_busy_o), 256'(1'b0));
        chk({name, ".count_hold"}, 256'(wb_count_o), 256'(n_exp));
    endtask

    initial begin
        rst_i       = 1'b1;
        flush_req_i = 1'b0;
        mem_ack_i   = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk_i);
        chk("rst.busy", 256'(flush_busy_o), 256'(0));
        chk("rst.done", 256'(flush_done_o), 256'(0));
        chk("rst.enable", 256'(mem_enable_o), 256'(0));
        chk("rst.write", 256'(mem_write_o), 256'(0));
        chk("rst.clr", 256'(sram_clr_dirty_o), 256'(0));
        chk("rst.addr", 256'(mem_addr_o), 256'(0));
        chk("rst.data", mem_data_o, 256'(0));
        chk("rst.count", 256'(wb_count_o), 256'(0));
        chk("rst.idx", 256'(sram_idx_o), 256'(0));
        chk("rst.way", 256'(sram_way_o), 256'(0));
        rst_i = 1'b0;
        @(negedge clk_i);

        // Empty cache: full walk with no traffic.
        run_flush("empty", 0, 0);

        // Single dirty line at set 0 way 0, ack after 10 cycles.
        clear_mem();
        tag_mem[0][0] = 25'h1800001;
        for (int k = 0; k < 16; k++) data_mem[0][0][k*16 +: 16] = 16'hECFA;
        run_flush("one_line", 10, 0);
        chk("one_line.dirty_cleared", 256'(tag_mem[0][0]), 256'(25'h1000001));

        // Two dirty lines in different ways: way 0 set 2 before way 1 set 15.
        clear_mem();
        tag_mem[1][15] = 25'h1800000;
        tag_mem[0][2]  = 25'h1800001;
        data_mem[1][15] = {8{32'h1111_2222}};
        data_mem[0][2]  = {8{32'h3333_4444}};
        run_flush("two_lines", 0, 0);

        // Valid-clean line plus invalid-dirty line.
        clear_mem();
        tag_mem[1][3] = 25'h1000002;
        tag_mem[0][7] = 25'h0800005;
        data_mem[1][3] = {8{32'hA5A5_5A5A}};
        run_flush("clean_line", 0, 0);

        // Random contents with stray requests/acks.
        for (int r = 0; r < 3; r++) begin
            random_mem();
            run_flush($sformatf("rand%0d", r), 0, 1);
        end

        // Reset three cycles into the ack wait.
        clear_mem();
        tag_mem[0][5]  = 25'h1800ABC;
        data_mem[0][5] = {8{32'hDEAD_BEEF}};
        @(negedge clk_i);
        flush_req_i = 1'b1;
        @(negedge clk_i);
        flush_req_i = 1'b0;
        for (int c = 0; c < 200 && !mem_enable_o; c++) @(negedge clk_i);
        chk("rstw.enable_seen", 256'(mem_enable_o), 256'(1));
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("rstw.enable", 256'(mem_enable_o), 256'(0));
        chk("rstw.busy", 256'(flush_busy_o), 256'(0));
        chk("rstw.count", 256'(wb_count_o), 256'(0));
        chk("rstw.clr", 256'(sram_clr_dirty_o), 256'(0));
        chk("rstw.idx", 256'(sram_idx_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("rstw.no_done", 256'(flush_done_o), 256'(0));
        end
        chk("rstw.still_dirty", 256'(tag_mem[0][5]), 256'(25'h1800ABC));
        run_flush("post_reset", 0, 0);

        // Level-held request re-triggers after DONE exits.
        clear_mem();
        @(negedge clk_i);
        flush_req_i = 1'b1;
        begin
            int c;
            for (c = 0; c < 300 && !flush_done_o; c++) @(negedge clk_i);
            chk("level.done1", 256'(flush_done_o), 256'(1));
        end
        @(negedge clk_i);
        chk("level.idle_gap", 256'(flush_busy_o), 256'(0));
        @(negedge clk_i);
        chk("level.retrigger", 256'(flush_busy_o), 256'(1));
        flush_req_i = 1'b0;
        begin
            int c;
            for (c = 0; c < 300 && !flush_done_o; c++) @(negedge clk_i);
            chk("level.done2", 256'(flush_done_o), 256'(1));
        end
        repeat (2) @(negedge clk_i);
        chk("level.idle_end", 256'(flush_busy_o), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dcache_flush_engine.md
Name: dcache_flush_engine

Overview:
- Memory-side initiator that walks every set/way of the 2-way data cache SRAM at end of run or on software request.
- Writes each dirty valid line back to Data_Memory over the standard 256-bit line interface: enable/write/addr/data out, ack/data in.
- Sits between dcache_sram (read port plus dirty-clear strobe) and the memory bus mux.
- Replaces the bench-side hierarchical flush loop with synthesizable hardware.

Parameters:
- NUM_SETS, 16, sets per way; index width IDX_W = log2(NUM_SETS) = 4.
- NUM_WAYS, 2, ways per set.
- TAG_W, 25, tag entry width: bit 24 = valid, bit 23 = dirty, bits 22:0 = address tag.
- LINE_W, 256, cache line / memory word width.
- ADDR_W, 32, byte address width; line offset is 5 bits.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- flush_req_i  input  1  start flush; sampled in IDLE only
- flush_busy_o  output  1  high from the cycle after the request is accepted until DONE exits; CPU stalls on it
- flush_done_o  output  1  one-cycle pulse at completion
- wb_count_o  output  6  lines written back by the last flush; holds until the next flush starts
- sram_idx_o  output  4  set index presented to the SRAM read port
- sram_way_o  output  1  way presented to the SRAM read port
- sram_tag_i  input  25  tag entry at idx/way, combinational same-cycle read
- sram_data_i  input  256  line data at idx/way, combinational same-cycle read
- sram_clr_dirty_o  output  1  one-cycle strobe: clear dirty bit at current idx/way
- mem_enable_o  output  1  memory request valid
- mem_write_o  output  1  request is a write; always 1 when enable is 1
- mem_addr_o  output  32  byte address {tag[22:0], idx, 5'b0}
- mem_data_o  output  256  write line
- mem_ack_i  input  1  memory completion, single-cycle pulse

Behaviour:
- Single clock clk_i; asynchronous active-high reset rst_i.
- Reset values:
  - state=IDLE.
  - flush_busy_o, flush_done_o, sram_clr_dirty_o, mem_enable_o, mem_write_o = 0.
  - mem_addr_o, mem_data_o, wb_count_o = 0.
  - idx = 0, way = 0.
- All outputs are registered.
- States: IDLE, READ, WRITE, CLEAR, NEXT, DONE.
- IDLE:
  - flush_req_i=1 at an edge -> READ.
  - That edge sets idx=0, way=0, busy=1, wb_count=0.
- READ (1 cycle): evaluate sram_tag_i.
  - need_wb = tag[24] & tag[23].
  - If need_wb: latch tag and data into mem_addr_o/mem_data_o, set mem_enable_o=1 and mem_write_o=1, -> WRITE.
  - Else -> NEXT.
- WRITE:
  - Hold enable, write, addr and data stable until mem_ack_i=1 is sampled.
  - On that edge: drop enable and write, wb_count+1, -> CLEAR.
  - No timeout; memory latency is unbounded.
- CLEAR (1 cycle): sram_clr_dirty_o=1 with idx/way unchanged -> NEXT.
- NEXT: scan order is way outer, set inner.
  - idx == NUM_SETS-1 and way == NUM_WAYS-1 -> DONE.
  - idx == NUM_SETS-1, way not last -> idx=0, way+1, -> READ.
  - Otherwise idx+1 -> READ.
- DONE: flush_done_o=1 for one cycle, busy=0 on exit -> IDLE.
- Boundary conditions:
  - flush_req_i while busy: ignored; no queuing.
  - flush_req_i asserted on the DONE cycle: ignored.
  - Level-held request re-triggers in IDLE.
  - mem_ack_i outside WRITE: ignored.
  - Valid but clean line: no memory traffic.
  - Invalid line with dirty bit set: ignored.
  - Reset mid-WRITE: mem_enable_o drops asynchronously; no dirty clear; wb_count_o=0.
- wb_count_o max = 32 (NUM_SETS*NUM_WAYS); 6 bits, never wraps.

Optional Feature:
- Macro: FLUSH_ALL_VALID_EN.
- Defined: need_wb = tag[24]. Every valid line is written back regardless of dirty bit, and CLEAR still strobes.
- Undefined: need_wb = tag[24] & tag[23], the default above.

Test Plan:
- All tags 0, request pulse at edge E -> no mem_enable_o ever. flush_done_o high in the cycle following edge E+64. wb_count_o=0. busy high for 65 cycles.
- Set 0 way 0 tag=25'h1800001, data=256'hECFA...ECFA; memory ack after 10 cycles:
  - mem_addr_o=32'h0000_0200 and mem_data_o=256'hECFA...ECFA stable until ack.
  - One sram_clr_dirty_o at idx0/way0.
  - wb_count_o=1; total flush = 65+10+1 cycles.
- Set 15 way 1 dirty tag 23'h0 plus set 2 way 0 dirty tag 23'h1:
  - Writes issued in order 0x240 (way0 set2) then 0x1E0 (way1 set15).
  - wb_count_o=2.
- Set 3 way 1 valid-clean tag=25'h1000002:
  - Default: no write.
  - With FLUSH_ALL_VALID_EN: one write to 0x460; wb_count_o=1.
- Reset asserted mid-WRITE (3 cycles into ack wait):
  - mem_enable_o=0 immediately, before the next edge.
  - State IDLE; no done pulse; a later request restarts at idx0/way0.
- flush_req_i pulsed again while busy, and mem_ack_i pulsed while in READ -> no extra flush, no count change, no spurious CLEAR.
